cpu_lapa_xlat: RTL and testbench
================================

CPU_LAPA_XLAT -- requirements
Module: cpu_lapa_xlat

Interface
REQ-001 Parameter LA_W, default 14, logical address page width (LA_23_10 generalised).
REQ-002 Parameter PPN_W, default 14, physical page number width; SHALL be >= LA_W.
REQ-003 Parameter ENTRIES, default 8, translation entries; power of two, 2..32.
REQ-004 sysclk  in  1  single clock; all state on rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 LAPA_n  in  1  per-request mode: 0 = bypass (PPN = zero-extended LA), 1 = translate.
REQ-007 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high.
REQ-008 req_la  in  LA_W  logical page for the request.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-010 rsp_ppn  out  PPN_W  resulting physical page number.
REQ-011 rsp_miss  out  1  translate-mode lookup found no valid matching entry.
REQ-012 wr_en, wr_idx[log2(ENTRIES)], wr_tag[LA_W], wr_ppn[PPN_W]  in  entry write port.
REQ-013 flush  in  1  invalidate all entries.

Function
REQ-014 Output stage SHALL be a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 req_ready SHALL equal (state==EMPTY) || rsp_ready, combinationally.
REQ-016 On a request transfer, the response SHALL be registered and visible the next cycle (latency 1); EMPTY->FULL, or FULL->FULL on simultaneous response and request transfer.
REQ-017 FULL->EMPTY SHALL occur on response transfer with no new request transfer.
REQ-018 While FULL and rsp_ready=0, rsp_ppn and rsp_miss SHALL hold stable.
REQ-019 Bypass: rsp_ppn = {zeros, req_la}, rsp_miss=0; the table is not consulted.
REQ-020 Translate: fully associative compare of req_la against all valid tags; a hit returns that entry's ppn with rsp_miss=0.
REQ-021 Multiple hits SHALL resolve to the lowest index.
REQ-022 Miss: rsp_ppn = 0, rsp_miss = 1.
REQ-023 A lookup in the same cycle as wr_en or flush SHALL see pre-write table contents.
REQ-024 wr_en SHALL set entry wr_idx to {valid=1, wr_tag, wr_ppn} at the clock edge.
REQ-025 flush SHALL clear every valid bit; flush with wr_en in the same cycle: flush wins, the write is dropped.
REQ-026 Table writes and flush SHALL not affect a response already held in FULL.

Reset
REQ-027 Asserting sys_rst_n low SHALL force EMPTY, rsp_valid=0, rsp_ppn=0, rsp_miss=0, and all valid bits=0 immediately, including mid-transfer; the held response is discarded.
REQ-028 Tag/ppn storage need not be reset.
REQ-029 After deassertion, req_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 Macro CPU_LAPA_XLAT_STATS_EN: when defined, outputs stat_hit[15:0] and stat_miss[15:0] exist; each increments once per translate-mode request transfer, saturates at 0xFFFF, and clears on reset or flush.
REQ-031 When undefined, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-032 Package cpu_lapa_pkg SHALL hold the default widths, the FSM state enum (EMPTY, FULL), and the entry struct typedef {valid, tag, ppn}.
REQ-033 Sub-module cpu_lapa_cam SHALL contain the entry storage, write/flush logic and the hit/index priority encoder; cpu_lapa_xlat contains the mode mux, FSM and statistics.

Verification
REQ-034 Reset, LAPA_n=0, req_la=0x1ABC, rsp_ready=1 -> next cycle rsp_valid=1, rsp_ppn=0x1ABC, rsp_miss=0.
REQ-035 Write idx 3 tag=0x0042 ppn=0x2F00, then translate 0x0042 -> rsp_ppn=0x2F00, miss=0; translate 0x0043 -> ppn=0, miss=1.
REQ-036 Idx 1 and 5 both tagged 0x0010 (ppn 0x111, 0x555), translate 0x0010 -> rsp_ppn=0x111.
REQ-037 rsp_ready=0 for 4 cycles while FULL -> req_ready=0, outputs stable; then back-to-back requests with rsp_ready=1 -> one response per cycle.
REQ-038 flush and wr_en same cycle, then lookup of written tag -> miss=1; lookup issued in the flush cycle of a valid tag -> hit.
REQ-039 sys_rst_n pulsed low while FULL -> rsp_valid drops asynchronously; with STATS_EN defined, stat_hit=stat_miss=0 afterwards.

Source files
------------

// File: rtl/cpu_lapa_pkg.sv
// Shared widths, output-stage state and translation entry layout
// for the logical-to-physical page translator.
package cpu_lapa_pkg;

  localparam int LA_W_DEF    = 14;
  localparam int PPN_W_DEF   = 14;
  localparam int ENTRIES_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lapa_state_e;

  typedef struct packed {
    logic                 valid;
    logic [LA_W_DEF-1:0]  tag;
    logic [PPN_W_DEF-1:0] ppn;
  } lapa_entry_t;

endpackage

// File: rtl/cpu_lapa_cam.sv
// Fully associative translation table: storage, write/flush
// and lowest-index hit selection.
module cpu_lapa_cam
  import cpu_lapa_pkg::*;
#(
  parameter int LA_W    = LA_W_DEF,
  parameter int PPN_W   = PPN_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [LA_W-1:0]  wr_tag,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             flush,
  input  logic [LA_W-1:0]  lk_tag,
  output logic             hit,
  output logic [PPN_W-1:0] hit_ppn
);

  typedef struct packed {
    logic             valid;
    logic [LA_W-1:0]  tag;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t tab [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        tab[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++)
        tab[i].valid <= 1'b0;
    end else if (wr_en) begin
      tab[wr_idx] <= '{valid: 1'b1,
                       tag:   wr_tag,
                       ppn:   wr_ppn};
    end
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tab[i].valid && tab[i].tag == lk_tag) begin
        hit     = 1'b1;
        hit_ppn = tab[i].ppn;
      end
    end
  end

endmodule

// File: rtl/cpu_lapa_xlat.sv
// Page translator top: mode mux, one-deep response stage, stats.
// Optional counters enabled by CPU_LAPA_XLAT_STATS_EN.
module cpu_lapa_xlat
  import cpu_lapa_pkg::*;
#(
  parameter int LA_W    = LA_W_DEF,
  parameter int PPN_W   = PPN_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             LAPA_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LA_W-1:0]  req_la,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PPN_W-1:0] rsp_ppn,
  output logic             rsp_miss,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [LA_W-1:0]  wr_tag,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             flush
`ifdef CPU_LAPA_XLAT_STATS_EN
  ,
  output logic [15:0]      stat_hit,
  output logic [15:0]      stat_miss
`endif
);

  lapa_state_e      state;
  logic             hit;
  logic [PPN_W-1:0] hit_ppn;
  logic             req_fire;
  logic             rsp_fire;
  logic [PPN_W-1:0] nxt_ppn;
  logic             nxt_miss;

  cpu_lapa_cam #(
    .LA_W    (LA_W),
    .PPN_W   (PPN_W),
    .ENTRIES (ENTRIES)
  ) u_cam (
    .clk     (sysclk),
    .rst_n   (sys_rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_tag  (wr_tag),
    .wr_ppn  (wr_ppn),
    .flush   (flush),
    .lk_tag  (req_la),
    .hit     (hit),
    .hit_ppn (hit_ppn)
  );

  assign rsp_valid = (state == FULL);
  assign req_ready = (state == EMPTY) || rsp_ready;
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_comb begin
    nxt_ppn  = PPN_W'(req_la);
    nxt_miss = 1'b0;
    if (LAPA_n) begin
      nxt_ppn  = hit ? hit_ppn : '0;
      nxt_miss = !hit;
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= EMPTY;
      rsp_ppn  <= '0;
      rsp_miss <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (req_fire) begin
            state    <= FULL;
            rsp_ppn  <= nxt_ppn;
            rsp_miss <= nxt_miss;
          end
        end
        FULL: begin
          if (req_fire) begin
            rsp_ppn  <= nxt_ppn;
            rsp_miss <= nxt_miss;
          end else if (rsp_fire) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef CPU_LAPA_XLAT_STATS_EN
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (flush) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (req_fire && LAPA_n) begin
      if (hit && stat_hit != 16'hFFFF)
        stat_hit <= stat_hit + 16'd1;
      if (!hit && stat_miss != 16'hFFFF)
        stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_lapa_xlat.sv
// Self-checking bench for cpu_lapa_xlat against a behavioural model.
// Stats checks compile in when CPU_LAPA_XLAT_STATS_EN is defined.
module tb_cpu_lapa_xlat;

  localparam int LA_W    = 14;
  localparam int PPN_W   = 14;
  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;

  logic             sysclk = 1'b0;
  logic             sys_rst_n;
  logic             LAPA_n;
  logic             req_valid;
  logic             req_ready;
  logic [LA_W-1:0]  req_la;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [PPN_W-1:0] rsp_ppn;
  logic             rsp_miss;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [LA_W-1:0]  wr_tag;
  logic [PPN_W-1:0] wr_ppn;
  logic             flush;
`ifdef CPU_LAPA_XLAT_STATS_EN
  logic [15:0]      stat_hit;
  logic [15:0]      stat_miss;
`endif

  always #5 sysclk = ~sysclk;

  cpu_lapa_xlat dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .LAPA_n    (LAPA_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_la    (req_la),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ppn   (rsp_ppn),
    .rsp_miss  (rsp_miss),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_ppn    (wr_ppn),
    .flush     (flush)
`ifdef CPU_LAPA_XLAT_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  // Reference model: table contents, held response, counters
  bit               m_valid [ENTRIES];
  logic [LA_W-1:0]  m_tag   [ENTRIES];
  logic [PPN_W-1:0] m_pt    [ENTRIES];
  bit               m_full;
  logic [PPN_W-1:0] m_ppn;
  bit               m_miss;
  int               m_hits;
  int               m_misses;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic void lookup(input bit mode,
                                 input logic [LA_W-1:0] la,
                                 output logic [PPN_W-1:0] p,
                                 output bit miss);
    p    = '0;
    miss = 1'b0;
    if (!mode) begin
      p = PPN_W'(la);
      return;
    end
    miss = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i] && m_tag[i] == la) begin
        p    = m_pt[i];
        miss = 1'b0;
        break;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_full   = 1'b0;
    m_ppn    = '0;
    m_miss   = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  task automatic idle();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    flush     = 1'b0;
  endtask

  // One clock: sample current inputs, advance model, land at edge+1
  task automatic tick();
    logic [PPN_W-1:0] p;
    bit ms, rf, sf, mode;
    rf   = req_valid && (!m_full || rsp_ready);
    sf   = m_full && rsp_ready;
    mode = LAPA_n;
    lookup(LAPA_n, req_la, p, ms);
    @(posedge sysclk);
    if (rf) begin
      m_full = 1'b1;
      m_ppn  = p;
      m_miss = ms;
    end else if (sf) begin
      m_full = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
    end else begin
      if (rf && mode) begin
        if (ms) m_misses = (m_misses < 65535) ? m_misses + 1 : 65535;
        else    m_hits   = (m_hits   < 65535) ? m_hits   + 1 : 65535;
      end
      if (wr_en) begin
        m_valid[wr_idx] = 1'b1;
        m_tag[wr_idx]   = wr_tag;
        m_pt[wr_idx]    = wr_ppn;
      end
    end
    #1;
  endtask

  task automatic wr(input int idx, input int tag, input int ppn);
    wr_en  = 1'b1;
    wr_idx = IDX_W'(idx);
    wr_tag = LA_W'(tag);
    wr_ppn = PPN_W'(ppn);
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic drain();
    idle();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rsp_ready = 1'b1;
    LAPA_n    = 1'b0;
    req_la    = '0;
    wr_idx    = '0;
    wr_tag    = '0;
    wr_ppn    = '0;
    sys_rst_n = 1'b0;
    model_reset();
    #12;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_ppn !== '0 || rsp_miss !== 1'b0)
      $display("FAIL reset_outputs got v=%b ppn=%h miss=%b want 0/0/0",
               rsp_valid, rsp_ppn, rsp_miss);
    else pass_cnt++;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    rsp_ready = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    rsp_ready = 1'b1;
    LAPA_n    = 1'b0;
    req_la    = 14'h1ABC;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_ppn !== 14'h1ABC || rsp_miss !== 1'b0)
      $display("FAIL bypass got v=%b ppn=%h miss=%b want 1/1abc/0",
               rsp_valid, rsp_ppn, rsp_miss);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL bypass_drain got v=%b want 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_translate();
    wr(3, 'h0042, 'h2F00);
    LAPA_n    = 1'b1;
    rsp_ready = 1'b1;
    req_la    = 14'h0042;
    req_valid = 1'b1;
    tick();
    total_cnt++;
    if (rsp_ppn !== 14'h2F00 || rsp_miss !== 1'b0)
      $display("FAIL xlat_hit got ppn=%h miss=%b want 2f00/0",
               rsp_ppn, rsp_miss);
    else pass_cnt++;
    req_la = 14'h0043;
    tick();
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_ppn !== '0 || rsp_miss !== 1'b1)
      $display("FAIL xlat_miss got v=%b ppn=%h miss=%b want 1/0/1",
               rsp_valid, rsp_ppn, rsp_miss);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_multi_hit();
    wr(5, 'h0010, 'h0555);
    wr(1, 'h0010, 'h0111);
    LAPA_n    = 1'b1;
    req_la    = 14'h0010;
    req_valid = 1'b1;
    tick();
    total_cnt++;
    if (rsp_ppn !== 14'h0111 || rsp_miss !== 1'b0)
      $display("FAIL multi_hit got ppn=%h miss=%b want 0111/0",
               rsp_ppn, rsp_miss);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    LAPA_n    = 1'b1;
    req_la    = 14'h0042;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    LAPA_n = 1'b0;
    req_la = 14'h1234;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (req_ready !== 1'b0)
        $display("FAIL stall_ready cyc%0d got %b want 0", c, req_ready);
      else pass_cnt++;
      if (c == 1) begin
        wr_en  = 1'b1;
        wr_idx = 3'd3;
        wr_tag = 14'h0042;
        wr_ppn = 14'h3333;
      end
      tick();
      wr_en = 1'b0;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_ppn !== 14'h2F00 || rsp_miss !== 1'b0)
        $display("FAIL stall_hold cyc%0d got v=%b ppn=%h want 1/2f00",
                 c, rsp_valid, rsp_ppn);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    tick();
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_ppn !== 14'h1234)
      $display("FAIL b2b_first got v=%b ppn=%h want 1/1234",
               rsp_valid, rsp_ppn);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      req_la = LA_W'(14'h0100 + k);
      total_cnt++;
      if (req_ready !== 1'b1)
        $display("FAIL b2b_ready k%0d got %b want 1", k, req_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_ppn !== PPN_W'(14'h0100 + k))
        $display("FAIL b2b_rsp k%0d got v=%b ppn=%h want 1/%h",
                 k, rsp_valid, rsp_ppn, 14'h0100 + k);
      else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_flush();
    wr(2, 'h0077, 'h0777);
    flush     = 1'b1;
    wr_en     = 1'b1;
    wr_idx    = 3'd4;
    wr_tag    = 14'h0088;
    wr_ppn    = 14'h0888;
    LAPA_n    = 1'b1;
    req_la    = 14'h0077;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    total_cnt++;
    if (rsp_ppn !== 14'h0777 || rsp_miss !== 1'b0)
      $display("FAIL flush_cycle_hit got ppn=%h miss=%b want 0777/0",
               rsp_ppn, rsp_miss);
    else pass_cnt++;
    req_la = 14'h0088;
    tick();
    total_cnt++;
    if (rsp_miss !== 1'b1 || rsp_ppn !== '0)
      $display("FAIL flush_drops_wr got ppn=%h miss=%b want 0/1",
               rsp_ppn, rsp_miss);
    else pass_cnt++;
    req_la = 14'h0077;
    tick();
    total_cnt++;
    if (rsp_miss !== 1'b1)
      $display("FAIL flush_clears got miss=%b want 1", rsp_miss);
    else pass_cnt++;
`ifdef CPU_LAPA_XLAT_STATS_EN
    total_cnt++;
    if (stat_hit !== 16'd0 || stat_miss !== 16'd2)
      $display("FAIL flush_stats got hit=%0d miss=%0d want 0/2",
               stat_hit, stat_miss);
    else pass_cnt++;
`endif
    drain();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      LAPA_n    = $urandom_range(0, 1);
      req_la    = ($urandom_range(0, 3) == 0) ?
                  LA_W'($urandom) : LA_W'($urandom_range(0, 15));
      wr_en     = ($urandom_range(0, 4) == 0);
      wr_idx    = IDX_W'($urandom);
      wr_tag    = LA_W'($urandom_range(0, 15));
      wr_ppn    = PPN_W'($urandom);
      flush     = ($urandom_range(0, 40) == 0);
      #1;
      total_cnt++;
      if (req_ready !== (!m_full || rsp_ready)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_ready n%0d got %b want %b",
                   n, req_ready, !m_full || rsp_ready);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (rsp_valid !== m_full ||
          (m_full && (rsp_ppn !== m_ppn || rsp_miss !== m_miss))) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_rsp n%0d got v=%b ppn=%h miss=%b want %b/%h/%b",
                   n, rsp_valid, rsp_ppn, rsp_miss, m_full, m_ppn, m_miss);
      end else pass_cnt++;
`ifdef CPU_LAPA_XLAT_STATS_EN
      total_cnt++;
      if (stat_hit !== 16'(m_hits) || stat_miss !== 16'(m_misses)) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand_stats n%0d got %0d/%0d want %0d/%0d",
                   n, stat_hit, stat_miss, m_hits, m_misses);
      end else pass_cnt++;
`endif
    end
    drain();
  endtask

  task automatic test_async_reset();
    wr(6, 'h0042, 'h0ABC);
    LAPA_n    = 1'b1;
    req_la    = 14'h0042;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b1)
      $display("FAIL arst_pre got v=%b want 1", rsp_valid);
    else pass_cnt++;
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_ppn !== '0 || rsp_miss !== 1'b0)
      $display("FAIL arst_async got v=%b ppn=%h miss=%b want 0/0/0",
               rsp_valid, rsp_ppn, rsp_miss);
    else pass_cnt++;
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL arst_ready got %b want 1", req_ready);
    else pass_cnt++;
`ifdef CPU_LAPA_XLAT_STATS_EN
    total_cnt++;
    if (stat_hit !== 16'd0 || stat_miss !== 16'd0)
      $display("FAIL arst_stats got %0d/%0d want 0/0", stat_hit, stat_miss);
    else pass_cnt++;
`endif
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_miss !== 1'b1 || rsp_ppn !== '0)
      $display("FAIL arst_table got v=%b miss=%b ppn=%h want 1/1/0",
               rsp_valid, rsp_miss, rsp_ppn);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_translate();
    test_multi_hit();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
